mmio_timer: RTL

Memory-mapped 16-bit timer peripheral that answers CPU data accesses on the MAB/MDB bus, acting as a second bus responder alongside the memory space. It decodes `MAB_in`, accepts word and byte writes from `MDB_in` under `MW`/`BW`, and returns register contents on its own `MDB_out`. It runs a prescaled counter with continuous and up-to-compare modes and raises a level interrupt request on rollover.

---
 rtl/mmio_timer_if.sv | 14 +
 rtl/mmio_timer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mmio_timer_if.sv
// CPU data-bus view of the timer: MAB/MDB address and data, write strobes,
// read-back data, address hit and interrupt request.
interface mmio_timer_if;
    logic [15:0] MAB_in;
    logic [15:0] MDB_in;
    logic        MW;
    logic        BW;
    logic [15:0] MDB_out;
    logic        SEL;
    logic        IRQ;

    modport master (output MAB_in, MDB_in, MW, BW, input MDB_out, SEL, IRQ);
    modport slave  (input MAB_in, MDB_in, MW, BW, output MDB_out, SEL, IRQ);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 16-bit timer: CTL/CNT/CCR registers, 3-bit prescaler,
// continuous and up-to-compare modes, level IRQ on rollover.
module mmio_timer #(
    parameter logic [15:0] BASE = 16'h0160
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus
);
    logic        ctl_en, ctl_mode, ctl_ie, ctl_ifg;
    logic [1:0]  ctl_div;
    logic [15:0] cnt, ccr;
    logic [2:0]  presc;

    logic        hit_ctl, hit_cnt, hit_ccr;
    logic        wr_cnt, wr_ccr, wr_ctl_lo, clr;
    logic [15:0] ctl_rd, reg_rd, cnt_wdata, ccr_wdata, cnt_next;
    logic [2:0]  presc_limit;
    logic        tick, wrap, hw_set;

    function automatic logic [15:0] byte_lane(input logic [15:0] r,
                                              input logic bw, input logic a0);
        if (!bw)    return r;
        else if (a0) return {8'h00, r[15:8]};
        else        return {8'h00, r[7:0]};
    endfunction

    function automatic logic [15:0] merge_write(input logic [15:0] old,
                                                input logic [15:0] wdata,
                                                input logic bw, input logic a0);
        if (!bw)    return wdata;
        else if (a0) return {wdata[7:0], old[7:0]};
        else        return {old[15:8], wdata[7:0]};
    endfunction

    assign hit_ctl = (bus.MAB_in[15:1] == BASE[15:1]);
    assign hit_cnt = (bus.MAB_in[15:1] == BASE[15:1] + 15'd1);
    assign hit_ccr = (bus.MAB_in[15:1] == BASE[15:1] + 15'd2);
    assign bus.SEL = hit_ctl | hit_cnt | hit_ccr;

    assign ctl_rd = {10'd0, ctl_ifg, ctl_ie, ctl_mode, ctl_div, ctl_en};

    always_comb begin
        reg_rd = 16'h0000;
        if (hit_ctl)      reg_rd = ctl_rd;
        else if (hit_cnt) reg_rd = cnt;
        else if (hit_ccr) reg_rd = ccr;
    end

    assign bus.MDB_out = (bus.SEL && !bus.MW) ? byte_lane(reg_rd, bus.BW, bus.MAB_in[0])
                                              : 16'h0000;

    // Every writable CTL bit sits in the low byte, so a high-byte write is a no-op.
    assign wr_ctl_lo = bus.MW & hit_ctl & (~bus.BW | ~bus.MAB_in[0]);
    assign wr_cnt    = bus.MW & hit_cnt;
    assign wr_ccr    = bus.MW & hit_ccr;
    assign clr       = wr_ctl_lo & bus.MDB_in[6];
    assign cnt_wdata = merge_write(cnt, bus.MDB_in, bus.BW, bus.MAB_in[0]);
    assign ccr_wdata = merge_write(ccr, bus.MDB_in, bus.BW, bus.MAB_in[0]);

    always_comb begin
        case (ctl_div)
            2'd0:    presc_limit = 3'd0;
            2'd1:    presc_limit = 3'd1;
            2'd2:    presc_limit = 3'd3;
            default: presc_limit = 3'd7;
        endcase
    end

    assign tick = ctl_en & (presc == presc_limit);

    always_comb begin
        cnt_next = cnt + 16'd1;
        wrap     = (cnt == 16'hFFFF);
        if (ctl_mode) begin
            wrap = (cnt == ccr);
            if (wrap) cnt_next = 16'h0000;
        end
    end

    // A CPU write to CNT or a CLR suppresses the tick, including its IFG set.
    assign hw_set = tick & wrap & ~wr_cnt & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_en   <= 1'b0;
            ctl_div  <= 2'd0;
            ctl_mode <= 1'b0;
            ctl_ie   <= 1'b0;
            ctl_ifg  <= 1'b0;
            cnt      <= 16'h0000;
            ccr      <= 16'h0000;
            presc    <= 3'd0;
        end else begin
            if (clr)
                presc <= 3'd0;
            else if (ctl_en)
                presc <= (presc == presc_limit) ? 3'd0 : presc + 3'd1;

            if (clr)
                cnt <= 16'h0000;
            else if (wr_cnt)
                cnt <= cnt_wdata;
            else if (tick)
                cnt <= cnt_next;

            if (wr_ccr)
                ccr <= ccr_wdata;

            if (wr_ctl_lo) begin
                ctl_en   <= bus.MDB_in[0];
                ctl_div  <= bus.MDB_in[2:1];
                ctl_mode <= bus.MDB_in[3];
                ctl_ie   <= bus.MDB_in[4];
            end

            // Software can only clear IFG; a same-edge hardware set wins.
            ctl_ifg <= hw_set | (ctl_ifg & ~(wr_ctl_lo & ~bus.MDB_in[5]));
        end
    end

    assign bus.IRQ = ctl_ie & ctl_ifg;
endmodule
